// File: rtl/i2c_pkg.sv
// Shared types and the per-slot line drive table for the I2C bit-level engine.
package i2c_pkg;

  localparam int unsigned NUM_SLOTS   = 5;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    SLOT_A = 3'd0,
    SLOT_B = 3'd1,
    SLOT_C = 3'd2,
    SLOT_D = 3'd3,
    SLOT_E = 3'd4
  } i2c_slot_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2c_state_t;

  // Open-drain enables: 1 = release, 0 = pull low
  typedef struct packed {
    logic scl;
    logic sda;
  } i2c_drive_t;

  function automatic i2c_slot_t next_slot(input i2c_slot_t s);
    if (32'(s) + 32'd1 < NUM_SLOTS) return i2c_slot_t'(3'(32'(s) + 32'd1));
    return SLOT_E;
  endfunction

  function automatic i2c_drive_t drive_lookup(input i2c_cmd_t  cmd,
                                              input i2c_slot_t slot,
                                              input logic      din,
                                              input logic      prev_scl);
    i2c_drive_t d;
    logic       mid;
    mid   = (slot == SLOT_B) || (slot == SLOT_C) || (slot == SLOT_D);
    d.scl = 1'b1;
    d.sda = 1'b1;
    case (cmd)
      CMD_START: begin
        d.scl = (slot == SLOT_A) ? prev_scl : (slot != SLOT_E);
        d.sda = (slot == SLOT_A) || (slot == SLOT_B);
      end
      CMD_STOP: begin
        d.scl = (slot != SLOT_A);
        d.sda = (slot == SLOT_D) || (slot == SLOT_E);
      end
      CMD_WRITE: begin
        d.scl = mid;
        d.sda = din;
      end
      default: begin
        d.scl = mid;
        d.sda = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_sync_2ff.sv
// Flop-chain synchronizer for an asynchronous bus line level.
module i2c_sync_2ff
  import i2c_pkg::*;
#(
  parameter logic        RESET_VALUE = 1'b1,
  parameter int unsigned STAGES      = SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {STAGES{RESET_VALUE}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_bit_controller.sv
// Bit-level I2C engine: runs one START/STOP/WRITE/READ primitive as five
// prescaled slots on open-drain SCL/SDA, with clock stretching and arbitration.
module i2c_bit_controller
  import i2c_pkg::*;
#(
  parameter int unsigned FREQ_SELECTION_BIT_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [FREQ_SELECTION_BIT_WIDTH-1:0] frequency_setting_i,
  input  logic [1:0]                          cmd_i,
  input  logic                                din_i,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  output logic                                done_o,
  output logic                                dout_o,
  output logic                                arb_lost_o,
  input  logic                                scl_i,
  input  logic                                sda_i,
  output logic                                scl_oen_o,
  output logic                                sda_oen_o
);

  localparam int unsigned W = FREQ_SELECTION_BIT_WIDTH;

  i2c_state_t state_q, state_d;
  i2c_slot_t  slot_q, slot_d;
  i2c_cmd_t   cmd_q, cmd_d;
  logic [W-1:0] cnt_q, cnt_d, p_q, p_d;
  logic din_q, din_d;
  logic scl_oen_q, scl_oen_d, sda_oen_q, sda_oen_d;
  logic ready_q, ready_d, done_q, done_d, arb_q, arb_d, dout_q, dout_d;
  logic scl_sync, sda_sync;
  logic tc_c, lost_c, stretch_c;
  i2c_drive_t drv;

  i2c_sync_2ff #(.RESET_VALUE(1'b1)) u_scl_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (scl_i),
    .q_o   (scl_sync)
  );

  i2c_sync_2ff #(.RESET_VALUE(1'b1)) u_sda_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sda_i),
    .q_o   (sda_sync)
  );

  assign tc_c      = (cnt_q == '0);
  // SDA sampled low where we are releasing it means another master won
  assign lost_c    = !sda_sync &&
                     (((cmd_q == CMD_START) && (slot_q == SLOT_B)) ||
                      ((cmd_q == CMD_WRITE) && din_q && (slot_q == SLOT_C)) ||
                      ((cmd_q == CMD_STOP)  && (slot_q == SLOT_E)));
  assign stretch_c = (slot_q == SLOT_B) && scl_oen_q && !scl_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      slot_q    <= SLOT_A;
      cmd_q     <= CMD_START;
      cnt_q     <= '0;
      p_q       <= '0;
      din_q     <= 1'b0;
      scl_oen_q <= 1'b1;
      sda_oen_q <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      arb_q     <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      din_q     <= din_d;
      scl_oen_q <= scl_oen_d;
      sda_oen_q <= sda_oen_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      arb_q     <= arb_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    din_d     = din_q;
    scl_oen_d = scl_oen_q;
    sda_oen_d = sda_oen_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    arb_d     = 1'b0;
    dout_d    = dout_q;
    drv       = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          drv       = drive_lookup(i2c_cmd_t'(cmd_i), SLOT_A, din_i, scl_oen_q);
          state_d   = ST_RUN;
          slot_d    = SLOT_A;
          cmd_d     = i2c_cmd_t'(cmd_i);
          din_d     = din_i;
          p_d       = frequency_setting_i;
          cnt_d     = frequency_setting_i;
          ready_d   = 1'b0;
          scl_oen_d = drv.scl;
          sda_oen_d = drv.sda;
        end
      end
      default: begin
        if (!tc_c) begin
          cnt_d = cnt_q - W'(1);
        end else begin
          if ((cmd_q == CMD_READ) && (slot_q == SLOT_C)) dout_d = sda_sync;
          if (lost_c) begin
            state_d   = ST_IDLE;
            ready_d   = 1'b1;
            done_d    = 1'b1;
            arb_d     = 1'b1;
            scl_oen_d = 1'b1;
            sda_oen_d = 1'b1;
          end else if (!stretch_c) begin
            if (slot_q == SLOT_E) begin
              // Lines keep their slot-E levels until the next command
              state_d = ST_IDLE;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              drv       = drive_lookup(cmd_q, next_slot(slot_q), din_q, scl_oen_q);
              slot_d    = next_slot(slot_q);
              cnt_d     = p_q;
              scl_oen_d = drv.scl;
              sda_oen_d = drv.sda;
            end
          end
        end
      end
    endcase
  end

  assign cmd_ready_o = ready_q;
  assign done_o      = done_q;
  assign arb_lost_o  = arb_q;
  assign dout_o      = dout_q;
  assign scl_oen_o   = scl_oen_q;
  assign sda_oen_o   = sda_oen_q;

endmodule

// File: tb/tb_i2c_bit_controller.sv
// Directed bench for i2c_bit_controller: vector table plus hand-built
// sequences for back-to-back commands, stretching, reset and prescale change.
module tb_i2c_bit_controller;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;
  localparam int BUDGET = 2000;

  logic        clk_i, rst_i;
  logic [15:0] frequency_setting_i;
  logic [1:0]  cmd_i;
  logic        din_i, cmd_valid_i;
  logic        cmd_ready_o, done_o, dout_o, arb_lost_o;
  logic        scl_i, sda_i, scl_oen_o, sda_oen_o;

  // Bus model: open-drain wired-AND with optional slave pulls
  logic scl_hold, sda_pull;
  assign scl_i = scl_oen_o & ~scl_hold;
  assign sda_i = sda_oen_o & ~sda_pull;

  i2c_bit_controller #(.FREQ_SELECTION_BIT_WIDTH(16)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .frequency_setting_i (frequency_setting_i),
    .cmd_i               (cmd_i),
    .din_i               (din_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .done_o              (done_o),
    .dout_o              (dout_o),
    .arb_lost_o          (arb_lost_o),
    .scl_i               (scl_i),
    .sda_i               (sda_i),
    .scl_oen_o           (scl_oen_o),
    .sda_oen_o           (sda_oen_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int passed, total;
  logic scl_hist [BUDGET+1];
  logic sda_hist [BUDGET+1];
  logic rdy_hist [BUDGET+1];
  logic last_scl;
  int   chg_k;
  logic [15:0] chg_val;

  typedef struct {
    logic [1:0]  cmd;
    logic        din;
    logic [15:0] p;
    int          pmode;     // 0 none, 1 SDA low always, 2 SDA low from slot B
    int          exp_done;
    logic        exp_arb;
    logic [1:0]  exp_end;   // {scl_oen, sda_oen} in the done cycle
    logic        chk_dout;
    logic        exp_dout;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [1:0] exp_drive(input logic [1:0] c, input int s,
                                           input logic d, input logic prev);
    logic mid;
    mid = (s >= 1) && (s <= 3);
    case (c)
      C_START: case (s)
                 0:       return {prev, 1'b1};
                 1:       return 2'b11;
                 2, 3:    return 2'b10;
                 default: return 2'b00;
               endcase
      C_STOP:  case (s)
                 0:       return 2'b00;
                 1, 2:    return 2'b10;
                 default: return 2'b11;
               endcase
      C_WRITE: return {mid, d};
      default: return {mid, 1'b1};
    endcase
  endfunction

  // Caller sits at a negedge; accept happens on the following posedge
  task automatic send(input logic [1:0] c, input logic d, input logic [15:0] p);
    check("ready_at_issue", int'(cmd_ready_o), 1);
    last_scl            = scl_oen_o;
    cmd_i               = c;
    din_i               = d;
    frequency_setting_i = p;
    cmd_valid_i         = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cmd_i       = ~c;
    din_i       = ~d;
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic d, input logic [15:0] p,
                         input int pmode, input int stretch_to,
                         output int done_k, output logic arb_v);
    done_k = -1;
    arb_v  = 1'b0;
    send(c, d, p);
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk_i);
      scl_hist[k] = scl_oen_o;
      sda_hist[k] = sda_oen_o;
      rdy_hist[k] = cmd_ready_o;
      sda_pull = (pmode == 1) || ((pmode == 2) && (k >= int'(p) + 2));
      scl_hold = (k >= 5) && (k <= stretch_to);
      if (k == chg_k) frequency_setting_i = chg_val;
      if (done_o) begin
        done_k = k;
        arb_v  = arb_lost_o;
        break;
      end
    end
    sda_pull = 1'b0;
    scl_hold = 1'b0;
  endtask

  task automatic wave_check(input string name, input logic [1:0] c, input logic d,
                            input logic [15:0] p, input int done_k);
    int bad, len, lim;
    bad = 0;
    len = int'(p) + 1;
    lim = (done_k > 0) ? done_k - 1 : 0;
    for (int k = 1; k <= lim; k++) begin
      if (k <= 5 * len &&
          {scl_hist[k], sda_hist[k]} != exp_drive(c, (k - 1) / len, d, last_scl)) bad++;
      if (rdy_hist[k]) bad++;
    end
    check(name, bad, 0);
  endtask

  vec_t vecs [12];
  int   dk, rises, falls, cnt;
  logic av;
  logic [1:0] seq_cmd [4];
  logic       seq_din [4];
  int         seq_pm  [4];

  initial begin
    passed = 0; total = 0;
    chg_k = 0; chg_val = '0;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = '0; din_i = 1'b0;
    frequency_setting_i = '0; scl_hold = 1'b0; sda_pull = 1'b0;

    vecs[0]  = '{C_WRITE, 1'b1, 16'd3, 0, 21, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[1]  = '{C_WRITE, 1'b0, 16'd3, 0, 21, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{C_READ,  1'b0, 16'd3, 0, 21, 1'b0, 2'b01, 1'b1, 1'b1};
    vecs[3]  = '{C_READ,  1'b1, 16'd2, 1, 16, 1'b0, 2'b01, 1'b1, 1'b0};
    vecs[4]  = '{C_START, 1'b0, 16'd3, 0, 21, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{C_STOP,  1'b0, 16'd2, 0, 16, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[6]  = '{C_WRITE, 1'b1, 16'd4, 2, 16, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[7]  = '{C_START, 1'b0, 16'd3, 2,  9, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[8]  = '{C_STOP,  1'b0, 16'd3, 1, 21, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[9]  = '{C_WRITE, 1'b0, 16'd3, 2, 21, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[10] = '{C_READ,  1'b0, 16'd3, 0, 21, 1'b0, 2'b01, 1'b1, 1'b1};
    vecs[11] = '{C_READ,  1'b0, 16'd3, 2, 21, 1'b0, 2'b01, 1'b1, 1'b0};

    // Reset values
    #12;
    check("rst_scl_oen", int'(scl_oen_o), 1);
    check("rst_sda_oen", int'(sda_oen_o), 1);
    check("rst_ready",   int'(cmd_ready_o), 1);
    check("rst_done",    int'(done_o), 0);
    check("rst_arb",     int'(arb_lost_o), 0);
    check("rst_dout",    int'(dout_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].cmd, vecs[i].din, vecs[i].p, vecs[i].pmode, 0, dk, av);
      check($sformatf("vec%0d_done_cycle", i), dk, vecs[i].exp_done);
      check($sformatf("vec%0d_arb", i), int'(av), int'(vecs[i].exp_arb));
      if (dk > 0) begin
        check($sformatf("vec%0d_end_lines", i), int'({scl_hist[dk], sda_hist[dk]}),
              int'(vecs[i].exp_end));
        check($sformatf("vec%0d_ready_at_done", i), int'(rdy_hist[dk]), 1);
      end
      wave_check($sformatf("vec%0d_wave", i), vecs[i].cmd, vecs[i].din, vecs[i].p, dk);
      if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), int'(dout_o), int'(vecs[i].exp_dout));
      @(negedge clk_i);
      check($sformatf("vec%0d_done_pulse", i), int'({done_o, arb_lost_o}), 0);
    end

    // Back-to-back START, WRITE 0, READ (slave drives 0), STOP
    seq_cmd = '{C_START, C_WRITE, C_READ, C_STOP};
    seq_din = '{1'b0, 1'b0, 1'b0, 1'b0};
    seq_pm  = '{0, 0, 1, 0};
    rises = 0; falls = 0;
    for (int i = 0; i < 4; i++) begin
      run_cmd(seq_cmd[i], seq_din[i], 16'd3, seq_pm[i], 0, dk, av);
      check($sformatf("seq%0d_done_gap", i), dk, 21);
      for (int k = 2; k <= dk && dk > 0; k++) begin
        if (scl_hist[k-1] && scl_hist[k] && sda_hist[k-1] && !sda_hist[k]) falls++;
        if (scl_hist[k-1] && scl_hist[k] && !sda_hist[k-1] && sda_hist[k]) rises++;
      end
      if (i == 2) check("seq_read_dout", int'(dout_o), 0);
    end
    check("seq_sda_fall_scl_high", falls, 1);
    check("seq_sda_rise_scl_high", rises, 1);

    // Clock stretch: slave holds SCL low through cycle 15
    @(negedge clk_i);
    run_cmd(C_WRITE, 1'b1, 16'd3, 0, 15, dk, av);
    check("stretch_done_cycle", dk, 31);
    check("stretch_arb", int'(av), 0);
    cnt = 0;
    for (int k = 1; k <= dk && dk > 0; k++) if (!sda_hist[k]) cnt++;
    check("stretch_sda_glitch", cnt, 0);

    // Reset during slot C of a START
    @(negedge clk_i);
    send(C_START, 1'b0, 16'd3);
    for (int k = 1; k <= 10; k++) @(negedge clk_i);
    check("midrst_pre_sda", int'(sda_oen_o), 0);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_scl_oen", int'(scl_oen_o), 1);
    check("midrst_sda_oen", int'(sda_oen_o), 1);
    check("midrst_ready",   int'(cmd_ready_o), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      if (done_o) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_cmd(C_STOP, 1'b0, 16'd3, 0, 0, dk, av);
    check("postrst_stop_done", dk, 21);
    check("postrst_stop_arb", int'(av), 0);
    if (dk > 0) check("postrst_stop_lines", int'({scl_hist[dk], sda_hist[dk]}), 3);

    // Prescale changed mid-command only affects the next command
    @(negedge clk_i);
    chg_k = 5; chg_val = 16'h0095;
    run_cmd(C_WRITE, 1'b0, 16'd3, 0, 0, dk, av);
    check("pchg_current_done", dk, 21);
    chg_k = 0;
    run_cmd(C_READ, 1'b0, 16'h0095, 0, 0, dk, av);
    check("pchg_next_done", dk, 751);
    wave_check("pchg_next_wave", C_READ, 1'b0, 16'h0095, dk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
